// File: rtl/four_byte_sender_tx_if.sv
// Transmit-side bus of the four-byte UART sender: word request in,
// serial line and status strobes out.
interface four_byte_sender_tx_if;
  logic        i_Tx_DV;
  logic [31:0] i_Tx_Four_Bytes;
  logic        o_Tx_Serial;
  logic        o_Tx_Active;
  logic        o_Tx_Done;

  // Requester side: supplies the word and watches the line/status
  modport master (
    output i_Tx_DV,
    output i_Tx_Four_Bytes,
    input  o_Tx_Serial,
    input  o_Tx_Active,
    input  o_Tx_Done
  );

  // Sender side: consumes the request and drives the line/status
  modport slave (
    input  i_Tx_DV,
    input  i_Tx_Four_Bytes,
    output o_Tx_Serial,
    output o_Tx_Active,
    output o_Tx_Done
  );
endinterface

// File: rtl/four_byte_sender_tx.sv
// Four-byte UART transmitter: sends a 32-bit word as four back-to-back
// 8N1 frames, least significant byte first, with no gap between bytes.
// All outputs come straight from flops so the line never glitches.
module four_byte_sender_tx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic                 CLK_25MHZ,
  input  logic                 RSTN,
  four_byte_sender_tx_if.slave tx_bus
);

  // At least one bit so a one-cycle bit period still has a legal counter
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT,
    CLEANUP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] clk_count, clk_count_n;
  logic [2:0]    bit_index, bit_index_n;
  logic [1:0]    byte_index, byte_index_n;
  logic [31:0]   tx_word, tx_word_n;
  logic          tx_serial, tx_serial_n;
  logic          tx_active, tx_active_n;
  logic          tx_done, tx_done_n;

  // State, counters, latched word and the registered outputs
  always_ff @(posedge CLK_25MHZ or posedge RSTN) begin
    if (RSTN) begin
      state      <= IDLE;
      clk_count  <= '0;
      bit_index  <= '0;
      byte_index <= '0;
      tx_word    <= '0;
      tx_serial  <= 1'b1;
      tx_active  <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_n;
      clk_count  <= clk_count_n;
      bit_index  <= bit_index_n;
      byte_index <= byte_index_n;
      tx_word    <= tx_word_n;
      tx_serial  <= tx_serial_n;
      tx_active  <= tx_active_n;
      tx_done    <= tx_done_n;
    end
  end

  // Next state plus outputs decoded from the next state, so the line
  // value registered on an edge belongs to the state entered on that edge
  always_comb begin
    state_n      = state;
    clk_count_n  = clk_count;
    bit_index_n  = bit_index;
    byte_index_n = byte_index;
    tx_word_n    = tx_word;

    case (state)
      IDLE: begin
        clk_count_n  = '0;
        bit_index_n  = '0;
        byte_index_n = '0;
        if (tx_bus.i_Tx_DV) begin
          tx_word_n = tx_bus.i_Tx_Four_Bytes;
          state_n   = START_BIT;
        end
      end

      START_BIT: begin
        if (clk_count == LAST_CLK) begin
          clk_count_n = '0;
          bit_index_n = '0;
          state_n     = DATA_BITS;
        end else begin
          clk_count_n = clk_count + 1'b1;
        end
      end

      DATA_BITS: begin
        if (clk_count == LAST_CLK) begin
          clk_count_n = '0;
          if (bit_index == 3'd7) begin
            bit_index_n = '0;
            state_n     = STOP_BIT;
          end else begin
            bit_index_n = bit_index + 1'b1;
          end
        end else begin
          clk_count_n = clk_count + 1'b1;
        end
      end

      STOP_BIT: begin
        if (clk_count == LAST_CLK) begin
          clk_count_n = '0;
          if (byte_index != 2'd3) begin
            byte_index_n = byte_index + 1'b1;
            state_n      = START_BIT;
          end else begin
            state_n = CLEANUP;
          end
        end else begin
          clk_count_n = clk_count + 1'b1;
        end
      end

      CLEANUP: begin
        clk_count_n  = '0;
        bit_index_n  = '0;
        byte_index_n = '0;
        state_n      = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    case (state_n)
      START_BIT: tx_serial_n = 1'b0;
      DATA_BITS: tx_serial_n = tx_word_n[{byte_index_n, bit_index_n}];
      default:   tx_serial_n = 1'b1;
    endcase

    tx_active_n = (state_n == START_BIT) || (state_n == DATA_BITS) ||
                  (state_n == STOP_BIT);
    tx_done_n   = (state_n == CLEANUP);
  end

  assign tx_bus.o_Tx_Serial = tx_serial;
  assign tx_bus.o_Tx_Active = tx_active;
  assign tx_bus.o_Tx_Done   = tx_done;

endmodule

// File: tb/tb_four_byte_sender_tx.sv
// Bench for four_byte_sender_tx at four clocks per bit: table of words
// with hand-decoded line bytes, plus back-to-back, mid-frame request and
// mid-frame reset sequences.
module tb_four_byte_sender_tx;

  localparam int CPB        = 4;
  localparam int LINE_CYCLES = 40 * CPB;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  four_byte_sender_tx_if tx_if ();

  four_byte_sender_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .CLK_25MHZ(clk),
    .RSTN     (rstn),
    .tx_bus   (tx_if)
  );

  typedef struct {
    string       name;
    logic [31:0] word;
    logic [7:0]  exp0;
    logic [7:0]  exp1;
    logic [7:0]  exp2;
    logic [7:0]  exp3;
  } vec_t;

  // Free-running 100 MHz sim clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case anything below stalls
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Present a word for one cycle; returns right after the accepting edge
  task automatic applyStimulus(input logic [31:0] word);
    tx_if.i_Tx_DV          = 1'b1;
    tx_if.i_Tx_Four_Bytes  = word;
    @(posedge clk);
  endtask

  // Walk the 160 line cycles after an accept edge, then the cleanup cycle.
  // inject_at > 0 pulses a competing request on that cycle; dv_in_cleanup
  // raises a request during the cleanup cycle (caller drops it).
  task automatic run_frame(input string name, input logic [7:0] e0,
                           input logic [7:0] e1, input logic [7:0] e2,
                           input logic [7:0] e3, input int inject_at,
                           input bit dv_in_cleanup);
    logic [7:0] exp_b [4];
    logic [7:0] got_b [4];
    int line_errs;
    int bitpos;
    int byte_no;
    int k;
    logic expb;
    exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = e2; exp_b[3] = e3;
    for (int i = 0; i < 4; i++) got_b[i] = 8'h00;
    line_errs = 0;
    for (int cyc = 1; cyc <= LINE_CYCLES; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        tx_if.i_Tx_DV         = 1'b0;
        tx_if.i_Tx_Four_Bytes = 32'hC3C3_3C3C;
      end
      if (cyc == inject_at) begin
        tx_if.i_Tx_DV         = 1'b1;
        tx_if.i_Tx_Four_Bytes = 32'hDEAD_BEEF;
      end else if (cyc == inject_at + 1) begin
        tx_if.i_Tx_DV = 1'b0;
      end
      bitpos  = (cyc - 1) / CPB;
      byte_no = bitpos / 10;
      k       = bitpos % 10;
      if (k == 0)      expb = 1'b0;
      else if (k == 9) expb = 1'b1;
      else             expb = exp_b[byte_no][k-1];
      if (tx_if.o_Tx_Serial !== expb || tx_if.o_Tx_Active !== 1'b1 ||
          tx_if.o_Tx_Done !== 1'b0)
        line_errs++;
      if (k >= 1 && k <= 8 && ((cyc - 1) % CPB) == CPB / 2)
        got_b[byte_no][k-1] = tx_if.o_Tx_Serial;
    end
    checkOutput({name, "_line_timing"}, line_errs, 0);
    checkOutput({name, "_byte0"}, {24'h0, got_b[0]}, {24'h0, e0});
    checkOutput({name, "_byte1"}, {24'h0, got_b[1]}, {24'h0, e1});
    checkOutput({name, "_byte2"}, {24'h0, got_b[2]}, {24'h0, e2});
    checkOutput({name, "_byte3"}, {24'h0, got_b[3]}, {24'h0, e3});
    // Cycle 161 counting the request cycle as 0: the cleanup cycle
    @(negedge clk);
    checkOutput({name, "_done_active_line"},
                {29'h0, tx_if.o_Tx_Done, tx_if.o_Tx_Active, tx_if.o_Tx_Serial},
                32'b101);
    if (dv_in_cleanup) begin
      tx_if.i_Tx_DV         = 1'b1;
      tx_if.i_Tx_Four_Bytes = 32'h0000_0000;
    end
  endtask

  // Line must sit idle: high, inactive, no done pulse
  task automatic idle_check(input string name, input int n);
    int errs;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_if.i_Tx_DV = 1'b0;
      if (tx_if.o_Tx_Serial !== 1'b1 || tx_if.o_Tx_Active !== 1'b0 ||
          tx_if.o_Tx_Done !== 1'b0)
        errs++;
    end
    checkOutput({name, "_idle"}, errs, 0);
  endtask

  // Main sequence
  initial begin
    vec_t vecs [6];
    checks   = 0;
    failures = 0;
    vecs[0] = '{"w25M",     32'h017D_7840, 8'h40, 8'h78, 8'h7D, 8'h01};
    vecs[1] = '{"zeros",    32'h0000_0000, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2] = '{"ones",     32'hFFFF_FFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    vecs[3] = '{"a5",       32'hA5A5_A5A5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    vecs[4] = '{"w1234",    32'h1234_5678, 8'h78, 8'h56, 8'h34, 8'h12};
    vecs[5] = '{"ends",     32'h8000_0001, 8'h01, 8'h00, 8'h00, 8'h80};

    rstn                  = 1'b1;
    tx_if.i_Tx_DV         = 1'b0;
    tx_if.i_Tx_Four_Bytes = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("reset_serial", {31'h0, tx_if.o_Tx_Serial}, 32'd1);
    checkOutput("reset_active", {31'h0, tx_if.o_Tx_Active}, 32'd0);
    checkOutput("reset_done",   {31'h0, tx_if.o_Tx_Done},   32'd0);
    rstn = 1'b0;
    idle_check("post_reset", 3);

    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      applyStimulus(vecs[v].word);
      run_frame(vecs[v].name, vecs[v].exp0, vecs[v].exp1, vecs[v].exp2,
                vecs[v].exp3, -1, 1'b0);
      idle_check(vecs[v].name, 3);
    end

    // Back-to-back at the earliest idle cycle: 2-cycle high gap
    @(negedge clk);
    applyStimulus(32'h0000_0000);
    run_frame("b2b_first", 8'h00, 8'h00, 8'h00, 8'h00, -1, 1'b0);
    @(negedge clk);
    checkOutput("b2b_gap_line_high", {31'h0, tx_if.o_Tx_Serial}, 32'd1);
    applyStimulus(32'hFFFF_FFFF);
    run_frame("b2b_second", 8'hFF, 8'hFF, 8'hFF, 8'hFF, -1, 1'b0);
    idle_check("b2b", 3);

    // Competing request mid-frame is ignored
    @(negedge clk);
    applyStimulus(32'h1234_5678);
    run_frame("midreq", 8'h78, 8'h56, 8'h34, 8'h12, 50, 1'b0);
    idle_check("midreq", 4);

    // Request during cleanup is ignored
    @(negedge clk);
    applyStimulus(32'hA5A5_A5A5);
    run_frame("cleanup_req", 8'hA5, 8'hA5, 8'hA5, 8'hA5, -1, 1'b1);
    idle_check("cleanup_req", 5);

    // Reset during byte 2 data bit 0 (0x34 bit0 = 0, line low)
    @(negedge clk);
    applyStimulus(32'h1234_5678);
    for (int cyc = 1; cyc <= 86; cyc++) begin
      @(negedge clk);
      if (cyc == 1) tx_if.i_Tx_DV = 1'b0;
    end
    checkOutput("pre_reset_line_low", {30'h0, tx_if.o_Tx_Serial, tx_if.o_Tx_Active},
                32'b01);
    rstn = 1'b1;
    #1;
    checkOutput("async_reset_outputs",
                {29'h0, tx_if.o_Tx_Serial, tx_if.o_Tx_Active, tx_if.o_Tx_Done},
                32'b100);
    repeat (2) @(negedge clk);
    checkOutput("held_reset_outputs",
                {29'h0, tx_if.o_Tx_Serial, tx_if.o_Tx_Active, tx_if.o_Tx_Done},
                32'b100);
    rstn = 1'b0;
    idle_check("after_abort", 8);
    @(negedge clk);
    applyStimulus(32'hA5A5_A5A5);
    run_frame("post_abort", 8'hA5, 8'hA5, 8'hA5, 8'hA5, -1, 1'b0);
    idle_check("post_abort", 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/four_byte_sender_tx.md
FOUR_BYTE_SENDER_TX -- requirements
Module: four_byte_sender_tx

Interface
REQ-001 The parameter SHALL be: CLKS_PER_BIT, default 217, meaning clock cycles per UART bit (25 MHz / 115200 baud).
REQ-002 Port: CLK_25MHZ  input  1  system clock, all state on rising edge.
REQ-003 Port: RSTN  input  1  reset, asynchronous, active-high.
REQ-004 Port: i_Tx_DV  input  1  single-cycle request to send i_Tx_Four_Bytes.
REQ-005 Port: i_Tx_Four_Bytes  input  32  word to transmit, sampled on the accept cycle.
REQ-006 Port: o_Tx_Serial  output  1  UART TX line, idle high.
REQ-007 Port: o_Tx_Active  output  1  high while a word is in flight.
REQ-008 Port: o_Tx_Done  output  1  single-cycle pulse when the final stop bit completes.

Function
REQ-009 Frame format SHALL be 8N1 per byte: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit held exactly CLKS_PER_BIT cycles.
REQ-010 Byte order SHALL be little-endian: bits[7:0] first, then [15:8], [23:16], [31:24].
REQ-011 FSM states SHALL be IDLE, START_BIT, DATA_BITS, STOP_BIT, CLEANUP.
REQ-012 IDLE: o_Tx_Serial=1 and o_Tx_Active=0; when i_Tx_DV=1, latch the word, clear the byte index to 0, assert o_Tx_Active and go to START_BIT on the next edge.
REQ-013 The first start-bit cycle on o_Tx_Serial SHALL be the cycle after the accept edge (latency 1 cycle).
REQ-014 START_BIT: drive 0 for CLKS_PER_BIT cycles, then go to DATA_BITS with the bit index at 0.
REQ-015 DATA_BITS: drive the current byte bit[index] for CLKS_PER_BIT cycles; increment the index; after index 7, go to STOP_BIT.
REQ-016 STOP_BIT: drive 1 for CLKS_PER_BIT cycles; if the byte index < 3, increment it and go directly to START_BIT with no idle gap; otherwise go to CLEANUP.
REQ-017 CLEANUP: lasts 1 cycle; assert o_Tx_Done=1, deassert o_Tx_Active, drive o_Tx_Serial=1; then go to IDLE.
REQ-018 A word SHALL occupy exactly 40*CLKS_PER_BIT cycles of line time, followed by 1 CLEANUP cycle.
REQ-019 i_Tx_DV asserted while o_Tx_Active=1 (including CLEANUP) SHALL be ignored; the latched word SHALL NOT change mid-frame.
REQ-020 Back-to-back: i_Tx_DV in the first IDLE cycle after CLEANUP SHALL be accepted; the minimum inter-word idle is 2 cycles of high line.
REQ-021 i_Tx_Four_Bytes changes after accept SHALL have no effect on the transmission.
REQ-022 The bit-period counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL reset to 0 at each bit boundary; the bit and byte indices SHALL NOT wrap mid-frame.
REQ-023 o_Tx_Serial SHALL be registered (glitch-free).

Reset
REQ-024 While RSTN=1, the block SHALL hold state IDLE, o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, and all counters and indices at 0.
REQ-025 RSTN asserted mid-frame SHALL abort immediately: the line returns high asynchronously, with no o_Tx_Done pulse, and no partial-word resumption after release.
REQ-026 After RSTN deasserts, the first i_Tx_DV SHALL be accepted normally.

Verification (CLKS_PER_BIT=4 in sim)
REQ-027 Send 32'd25000000 (0x017D7840) -> line bytes in order 0x40, 0x78, 0x7D, 0x01; o_Tx_Done pulses once, 161 cycles after accept.
REQ-028 Send 0x00000000, then 0xFFFFFFFF, back-to-back at the earliest IDLE -> start bits and stop bits are correct, data are all-0 then all-1, and the inter-word high gap is exactly 2 cycles.
REQ-029 Pulse i_Tx_DV with 0xDEADBEEF in the middle of a 0x12345678 frame -> only 0x78, 0x56, 0x34, 0x12 are sent; a single o_Tx_Done pulse.
REQ-030 Assert RSTN during byte 2 data bits -> o_Tx_Serial=1 and o_Tx_Active=0 immediately; no o_Tx_Done; after release, a 0xA5A5A5A5 send completes correctly.
REQ-031 Loopback to the team four-byte receiver at CLKS_PER_BIT=217: send 32'd25000000 -> the receiver presents 32'd25000000 with its valid strobe.
REQ-032 Check bit timing: every line transition is a multiple of CLKS_PER_BIT cycles from the start-bit falling edge.
